// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, control-word layout, default control
// vectors and the hazard FSM state encoding.
package decode_pkg;

  localparam int CTRL_W = 9;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // Control word bit positions, MSB first: regDst down to aluOp[1:0]
  localparam int CTRL_REGDST   = 8;
  localparam int CTRL_ALUSRC   = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_ALUOP_LSB = 0;

  typedef logic [CTRL_W-1:0] ctrlT;

  localparam ctrlT CTRL_RTYPE = 9'b1_0_0_1_0_0_0_10;
  localparam ctrlT CTRL_LW    = 9'b0_1_1_1_1_0_0_00;
  localparam ctrlT CTRL_SW    = 9'b0_1_0_0_0_1_0_00;
  localparam ctrlT CTRL_BEQ   = 9'b0_0_0_0_0_0_1_01;
  localparam ctrlT CTRL_ADDI  = 9'b0_1_0_1_0_0_0_00;
  localparam ctrlT CTRL_NONE  = '0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stateT;

  function automatic ctrlT decodeCtrl(input logic [5:0] opcode);
    case (opcode)
      OP_RTYPE: decodeCtrl = CTRL_RTYPE;
      OP_LW:    decodeCtrl = CTRL_LW;
      OP_SW:    decodeCtrl = CTRL_SW;
      OP_BEQ:   decodeCtrl = CTRL_BEQ;
      OP_ADDI:  decodeCtrl = CTRL_ADDI;
      default:  decodeCtrl = CTRL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Register file with two asynchronous read ports and one write port; a write
// in the same cycle as a read of the same nonzero index is forwarded.
module regfile_bypass #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int RA    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA-1:0]   rsIdx,
  input  logic [RA-1:0]   rtIdx,
  output logic [XLEN-1:0] rsData,
  output logic [XLEN-1:0] rtData,
  input  logic            wbWe,
  input  logic [RA-1:0]   wbRd,
  input  logic [XLEN-1:0] wbData
);

  logic [XLEN-1:0] regs [NREGS];

  // Register zero is hardwired: writes to it are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wbWe && (wbRd != '0)) begin
      regs[wbRd] <= wbData;
    end
  end

  assign rsData = (rsIdx == '0)                ? '0     :
                  (wbWe && (wbRd == rsIdx))    ? wbData : regs[rsIdx];
  assign rtData = (rtIdx == '0)                ? '0     :
                  (wbWe && (wbRd == rtIdx))    ? wbData : regs[rtIdx];

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: instruction decode, operand fetch, load-use hazard FSM and the
// ID/EX pipeline register with valid/ready handshakes on both sides.
module decode_pipe
  import decode_pkg::*;
#(
  parameter  int XLEN         = 32,
  parameter  int NREGS        = 32,
  parameter  int LOAD_BUBBLES = 1,
  parameter  bit IMM_SIGNED   = 1'b1,
  localparam int RA           = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [RA-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_rs_data,
  output logic [XLEN-1:0]   out_rt_data,
  output logic [XLEN-1:0]   out_imm,
  output logic [RA-1:0]     out_rs,
  output logic [RA-1:0]     out_rt,
  output logic [RA-1:0]     out_rd
);

  logic [5:0]      opcode;
  logic [RA-1:0]   instrRs;
  logic [RA-1:0]   instrRt;
  logic [RA-1:0]   instrRd;
  logic [RA-1:0]   destIdx;
  logic [XLEN-1:0] rsData;
  logic [XLEN-1:0] rtData;
  logic [XLEN-1:0] immExt;
  ctrlT            decCtrl;

  stateT           state;
  stateT           nextState;
  logic [1:0]      cnt;
  logic [1:0]      nextCnt;
  logic            hazard;
  logic            loadInstr;
  logic            loadBubble;

  assign opcode  = in_instr[31:26];
  assign instrRs = RA'(in_instr[25:21]);
  assign instrRt = RA'(in_instr[20:16]);
  assign instrRd = RA'(in_instr[15:11]);
  assign decCtrl = decodeCtrl(opcode);
  assign destIdx = decCtrl[CTRL_REGDST] ? instrRd : instrRt;
  assign immExt  = IMM_SIGNED ? {{(XLEN-16){in_instr[15]}}, in_instr[15:0]}
                              : {{(XLEN-16){1'b0}}, in_instr[15:0]};

  regfile_bypass #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) uRegfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .rsIdx  (instrRs),
    .rtIdx  (instrRt),
    .rsData (rsData),
    .rtData (rtData),
    .wbWe   (wb_we),
    .wbRd   (wb_rd),
    .wbData (wb_data)
  );

  // A load sitting in ID/EX whose destination feeds the presented instruction.
  assign hazard = out_valid && out_ctrl[CTRL_MEMREAD] && (out_rt != '0) &&
                  ((out_rt == instrRs) || (out_rt == instrRt)) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // The hazard cycle itself loads the first bubble; STALL supplies the rest,
  // with cnt holding how many bubbles remain once STALL is entered.
  always_comb begin
    nextState  = state;
    nextCnt    = cnt;
    in_ready   = 1'b0;
    loadInstr  = 1'b0;
    loadBubble = 1'b0;
    case (state)
      STALL: begin
        if (out_ready) begin
          loadBubble = 1'b1;
          if (cnt <= 2'd1) begin
            nextState = RUN;
            nextCnt   = 2'd0;
          end else begin
            nextCnt = cnt - 2'd1;
          end
        end
      end
      default: begin
        if (hazard) begin
          if (out_ready) begin
            loadBubble = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              nextState = STALL;
              nextCnt   = 2'(LOAD_BUBBLES - 1);
            end
          end
        end else begin
          in_ready  = !out_valid || out_ready;
          loadInstr = in_valid && in_ready;
        end
      end
    endcase
    if (flush) begin
      nextState  = RUN;
      nextCnt    = 2'd0;
      loadInstr  = 1'b0;
      loadBubble = 1'b0;
    end
  end

  // ID/EX register; a bubble keeps the previous operands and only zeroes ctrl.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_ctrl    <= '0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_imm     <= '0;
      out_rs      <= '0;
      out_rt      <= '0;
      out_rd      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (loadInstr) begin
      out_valid   <= 1'b1;
      out_ctrl    <= decCtrl;
      out_rs_data <= rsData;
      out_rt_data <= rtData;
      out_imm     <= immExt;
      out_rs      <= instrRs;
      out_rt      <= instrRt;
      out_rd      <= destIdx;
    end else if (loadBubble) begin
      out_valid <= 1'b1;
      out_ctrl  <= '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: a transaction-level scoreboard of
// expected ID/EX transfers plus hand-computed literal checks.
module tb_decode_pipe;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int LB = 2;
  localparam bit IMM_SIGNED = 1'b1;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } expT;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        inValid, inReady, flush, wbWe, outValid, outReady;
  logic [31:0] inInstr, wbData, outRsData, outRtData, outImm;
  logic [4:0]  wbRd, outRs, outRt, outRd;
  logic [8:0]  outCtrl;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] modelRegs [32];
  expT         expQ [$];

  decode_pipe #(
    .XLEN         (XLEN),
    .NREGS        (NREGS),
    .LOAD_BUBBLES (LB),
    .IMM_SIGNED   (IMM_SIGNED)
  ) dut (
    .clk         (clk),
    .rst_n       (rstN),
    .in_valid    (inValid),
    .in_ready    (inReady),
    .in_instr    (inInstr),
    .flush       (flush),
    .wb_we       (wbWe),
    .wb_rd       (wbRd),
    .wb_data     (wbData),
    .out_valid   (outValid),
    .out_ready   (outReady),
    .out_ctrl    (outCtrl),
    .out_rs_data (outRsData),
    .out_rt_data (outRtData),
    .out_imm     (outImm),
    .out_rs      (outRs),
    .out_rt      (outRt),
    .out_rd      (outRd)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] specCtrl(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b1_0_0_1_0_0_0_10;
      6'h23:   return 9'b0_1_1_1_1_0_0_00;
      6'h2B:   return 9'b0_1_0_0_0_1_0_00;
      6'h04:   return 9'b0_0_0_0_0_0_1_01;
      6'h08:   return 9'b0_1_0_1_0_0_0_00;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] readModel(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wbWe && (wbRd == idx)) return wbData;
    return modelRegs[idx];
  endfunction

  function automatic expT predict(input logic [31:0] instr);
    expT e;
    e.ctrl   = specCtrl(instr[31:26]);
    e.rs     = instr[25:21];
    e.rt     = instr[20:16];
    e.rd     = e.ctrl[8] ? instr[15:11] : instr[20:16];
    e.rsData = readModel(instr[25:21]);
    e.rtData = readModel(instr[20:16]);
    e.imm    = IMM_SIGNED ? {{16{instr[15]}}, instr[15:0]} : {16'd0, instr[15:0]};
    return e;
  endfunction

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every ID/EX transfer must match the head of the expected queue;
  // a transferring load with a dependent instruction waiting queues LB bubbles.
  always @(negedge clk) begin
    expT e;
    expT act;
    if (!rstN) begin
      expQ.delete();
      for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
    end else begin
      if (outValid && outReady) begin
        act = '{ctrl: outCtrl, rsData: outRsData, rtData: outRtData, imm: outImm,
                rs: outRs, rt: outRt, rd: outRd};
        testsRun++;
        if (expQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL transfer: got %h with nothing expected", act);
        end else begin
          e = expQ.pop_front();
          if (act !== e) begin
            testsFailed++;
            $display("[TB] FAIL transfer: got %h expected %h", act, e);
          end
          if (!flush && inValid && (e.ctrl == 9'h0F0) && (e.rt != 5'd0) &&
              ((inInstr[25:21] == e.rt) || (inInstr[20:16] == e.rt))) begin
            for (int b = 0; b < LB; b++) begin
              expT bub;
              bub = e;
              bub.ctrl = 9'd0;
              expQ.push_back(bub);
            end
          end
        end
      end
      if (flush) begin
        expQ.delete();
      end else if (inValid && inReady) begin
        expQ.push_back(predict(inInstr));
      end
      if (wbWe && (wbRd != 5'd0)) modelRegs[wbRd] = wbData;
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents an instruction until accepted; returns just after the loading edge.
  task automatic applyStimulus(input logic [31:0] instr);
    bit accepted;
    accepted = 1'b0;
    inValid = 1'b1;
    inInstr = instr;
    for (int c = 0; c < 20 && !accepted; c++) begin
      @(negedge clk);
      accepted = inReady;
      nextCycle();
    end
    inValid = 1'b0;
    if (!accepted) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL accept timeout: instr 0x%0h never accepted", instr);
    end
  endtask

  initial begin
    inValid = 1'b0; inInstr = '0; flush = 1'b0;
    wbWe = 1'b0; wbRd = '0; wbData = '0; outReady = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", outValid, 0);
    checkOutput("reset out_ctrl", outCtrl, 0);
    checkOutput("reset out_rs_data", outRsData, 0);
    checkOutput("reset out_rd", outRd, 0);
    nextCycle();
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after reset", inReady, 1);

    // Write $5 then add $3,$5,$0
    nextCycle();
    wbWe = 1'b1; wbRd = 5'd5; wbData = 32'h1234;
    nextCycle();
    wbWe = 1'b0;
    applyStimulus(rType(5'd5, 5'd0, 5'd3));
    @(negedge clk);
    checkOutput("add valid", outValid, 1);
    checkOutput("add rs_data", outRsData, 32'h1234);
    checkOutput("add rd", outRd, 3);
    checkOutput("add ctrl", outCtrl, 9'h122);
    @(negedge clk);
    checkOutput("idle clears valid", outValid, 0);

    // Same-cycle write-back bypass into addi $8,$7,5
    nextCycle();
    wbWe = 1'b1; wbRd = 5'd7; wbData = 32'hBEEF;
    applyStimulus(iType(6'h08, 5'd7, 5'd8, 16'd5));
    wbWe = 1'b0;
    @(negedge clk);
    checkOutput("bypass rs_data", outRsData, 32'hBEEF);
    checkOutput("addi ctrl", outCtrl, 9'h0A0);
    checkOutput("addi rd", outRd, 8);
    checkOutput("addi imm", outImm, 5);

    // Write to $0 is ignored; add $9,$0,$7
    nextCycle();
    wbWe = 1'b1; wbRd = 5'd0; wbData = 32'hDEAD;
    nextCycle();
    wbWe = 1'b0;
    applyStimulus(rType(5'd0, 5'd7, 5'd9));
    @(negedge clk);
    checkOutput("r0 reads zero", outRsData, 0);
    checkOutput("stored $7", outRtData, 32'hBEEF);

    // Output held for 4 cycles with sw waiting
    nextCycle();
    applyStimulus(rType(5'd5, 5'd7, 5'd10));
    outReady = 1'b0;
    inValid = 1'b1;
    inInstr = iType(6'h2B, 5'd7, 5'd5, 16'd8);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("hold valid", outValid, 1);
      checkOutput("hold ctrl", outCtrl, 9'h122);
      checkOutput("hold rd", outRd, 10);
      checkOutput("hold rs_data", outRsData, 32'h1234);
      checkOutput("hold in_ready", inReady, 0);
      nextCycle();
    end
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("release in_ready", inReady, 1);
    nextCycle();
    inValid = 1'b0;
    @(negedge clk);
    checkOutput("sw ctrl", outCtrl, 9'h088);

    // lw $2,4($1) then dependent add $4,$2,$3
    nextCycle();
    applyStimulus(iType(6'h23, 5'd1, 5'd2, 16'd4));
    inValid = 1'b1;
    inInstr = rType(5'd2, 5'd3, 5'd4);
    @(negedge clk);
    checkOutput("lw ctrl", outCtrl, 9'h0F0);
    checkOutput("hazard in_ready", inReady, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("bubble1 valid", outValid, 1);
    checkOutput("bubble1 ctrl", outCtrl, 0);
    checkOutput("stall in_ready", inReady, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("bubble2 valid", outValid, 1);
    checkOutput("bubble2 ctrl", outCtrl, 0);
    checkOutput("after stall in_ready", inReady, 1);
    nextCycle();
    inValid = 1'b0;
    @(negedge clk);
    checkOutput("dependent ctrl", outCtrl, 9'h122);
    checkOutput("dependent rd", outRd, 4);

    // Flush during first bubble
    nextCycle();
    applyStimulus(iType(6'h23, 5'd1, 5'd2, 16'd4));
    inValid = 1'b1;
    inInstr = rType(5'd2, 5'd3, 5'd4);
    nextCycle();
    flush = 1'b1;
    @(negedge clk);
    checkOutput("pre-flush bubble ctrl", outCtrl, 0);
    nextCycle();
    flush = 1'b0;
    inValid = 1'b0;
    @(negedge clk);
    checkOutput("flush valid", outValid, 0);
    checkOutput("flush ctrl", outCtrl, 0);
    checkOutput("flush in_ready", inReady, 1);
    nextCycle();
    applyStimulus(iType(6'h08, 5'd0, 5'd11, 16'hFFFC));
    @(negedge clk);
    checkOutput("signed imm", outImm, 32'hFFFFFFFC);

    // Reset in the middle of a stall
    nextCycle();
    applyStimulus(iType(6'h23, 5'd1, 5'd2, 16'd4));
    inValid = 1'b1;
    inInstr = rType(5'd2, 5'd3, 5'd4);
    nextCycle();
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async reset valid", outValid, 0);
    inValid = 1'b0;
    @(negedge clk);
    nextCycle();
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after mid-stall reset", inReady, 1);
    nextCycle();
    applyStimulus(rType(5'd5, 5'd7, 5'd12));
    @(negedge clk);
    checkOutput("regfile cleared rs", outRsData, 0);
    checkOutput("regfile cleared rt", outRtData, 0);

    repeat (3) nextCycle();
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
